// File: rtl/manual_drive.sv
// Manual-mode driving controller: gear/pedal FSM, illegal-operation power-off
// pulse, turn-signal blinking and saturating mileage accumulation.
module manual_drive #(
  parameter int BLINK_DIV = 250,
  parameter int MILE_DIV  = 50,
  parameter int MILE_W    = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic              throttle,
  input  logic              clutch,
  input  logic              brake,
  input  logic              reverse,
  input  logic              turn_left,
  input  logic              turn_right,
  output logic [1:0]        drive_state,
  output logic              power_off,
  output logic              reversing,
  output logic              left_led,
  output logic              right_led,
  output logic [MILE_W-1:0] mileage
);

  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int MW = (MILE_DIV > 1) ? $clog2(MILE_DIV) : 1;

  typedef enum logic [1:0] {
    NOT_STARTING = 2'b00,
    STARTING     = 2'b01,
    MOVING       = 2'b10
  } state_t;

  state_t          state, state_nxt;
  logic            kill, reverse_q, phase, illegal, active, turn_req;
  logic [BW-1:0]   blink_cnt;
  logic [MW-1:0]   mile_cnt;

  function automatic logic [MILE_W-1:0] sat_inc(input logic [MILE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // rst_n gates active so outputs read 0 while reset is held, whatever mode says
  assign active      = rst_n & (mode == 2'b01) & ~kill;
  assign turn_req    = turn_left | turn_right;
  assign reversing   = reverse & active;
  assign left_led    = active & turn_left & phase;
  assign right_led   = active & turn_right & phase;
  assign drive_state = state;

  always_comb begin
    state_nxt = state;
    illegal   = 1'b0;
    if (!active) begin
      state_nxt = NOT_STARTING;
    end else begin
      case (state)
        NOT_STARTING: begin
          if (throttle && !clutch)                 illegal   = 1'b1;
          else if (throttle && clutch && !brake)   state_nxt = STARTING;
        end
        STARTING: begin
          if (brake)                               state_nxt = NOT_STARTING;
          else if (throttle && !clutch)            state_nxt = MOVING;
        end
        MOVING: begin
          if ((reverse != reverse_q) && !clutch) begin
            illegal   = 1'b1;
            state_nxt = NOT_STARTING;
          end
          else if (brake)                          state_nxt = NOT_STARTING;
          else if (clutch || !throttle)            state_nxt = STARTING;
        end
        default:                                   state_nxt = NOT_STARTING;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= NOT_STARTING;
      power_off <= 1'b0;
      kill      <= 1'b0;
      reverse_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      power_off <= active & illegal;
      reverse_q <= reverse;
      if (mode != 2'b01)          kill <= 1'b0;
      else if (active && illegal) kill <= 1'b1;
    end
  end

  // Idle blinker parks with phase high so a new request lights at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (active && turn_req) begin
      if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end else begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mile_cnt <= '0;
      mileage  <= '0;
    end else if (active && state == MOVING) begin
      if (mile_cnt == MW'(MILE_DIV - 1)) begin
        mile_cnt <= '0;
        mileage  <= sat_inc(mileage);
      end else begin
        mile_cnt <= mile_cnt + 1'b1;
      end
    end else begin
      mile_cnt <= '0;
    end
  end

endmodule

// File: doc/manual_drive.md
# manual_drive

Manual-mode driving controller for the car simulation. It sits directly downstream of the power/mode block and consumes its 2-bit `mode` output. When `mode` selects manual driving, it runs the NOT_STARTING / STARTING / MOVING gear-and-pedal state machine, drives the turn-signal LEDs and reverse indicator, and accumulates mileage. It issues a one-cycle `power_off` pulse on illegal operation; the top level wires this pulse to the power block's `break` input.

## Interface
Parameters:
- `BLINK_DIV`, 250: cycles per turn-LED phase (2 ms clock gives 0.5 s on / 0.5 s off).
- `MILE_DIV`, 50: cycles of MOVING per mileage unit.
- `MILE_W`, 20: mileage counter width.

Ports:
- `clk` input 1: system clock, 2 ms period. Only clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `mode` input 2: from the power block. 00 = off, 01 = manual, 11 = semi-auto, 10 = auto. This block is active only on 01.
- `throttle`, `clutch`, `brake`, `reverse` input 1 each: level inputs, already debounced.
- `turn_left`, `turn_right` input 1 each: turn switches.
- `drive_state` output 2: 00 = NOT_STARTING, 01 = STARTING, 10 = MOVING. The value 11 is never driven.
- `power_off` output 1: registered, one-cycle pulse.
- `reversing` output 1: `reverse & active`.
- `left_led`, `right_led` output 1 each: blinking turn indicators.
- `mileage` output `MILE_W`: accumulated distance. It saturates at all ones.

## Operation
- `active` = (`mode` == 01) & !`kill`.
- `kill` is a register. It is set on the cycle `power_off` is issued and cleared when `mode` != 01. While `kill` is set, no further `power_off` pulse can occur.
- When not active:
  - `drive_state` is forced to NOT_STARTING on the next edge.
  - The blink and mile sub-counters are cleared.
  - `mileage` holds its value.
  - All LEDs and `reversing` are 0.
- FSM transitions are evaluated each edge while active. The first matching rule wins.
  - **NOT_STARTING:**
    1. `throttle & !clutch` → `power_off`, stay.
    2. `throttle & clutch & !brake` → STARTING.
    3. Otherwise stay.
  - **STARTING:**
    1. `brake` → NOT_STARTING.
    2. `throttle & !clutch` → MOVING.
    3. Otherwise stay.
  - **MOVING:**
    1. `reverse` != `reverse_q` and `!clutch` → `power_off`, go to NOT_STARTING.
    2. `brake` → NOT_STARTING.
    3. `clutch | !throttle` → STARTING.
    4. Otherwise stay.
- `reverse_q` is `reverse` registered every cycle, regardless of `active`.
- Blink counter:
  - Counts while active & (`turn_left | turn_right`).
  - At `BLINK_DIV`-1 it wraps to 0 and `phase` toggles.
  - With no turn request it holds counter = 0 and `phase` = 1, so the LED lights immediately on request.
  - `left_led` = `active & turn_left & phase`.
  - `right_led` = `active & turn_right & phase`.
  - Both LEDs may be on together.
- Mileage:
  - The sub-counter counts while `drive_state` == MOVING and active.
  - At `MILE_DIV`-1 it wraps to 0 and `mileage` increments, saturating at 2^`MILE_W`-1.
  - The sub-counter is cleared on leaving MOVING. Partial units are discarded.
  - `mileage` is cleared only by `rst_n`.

## Timing
- Reset (`rst_n` low, asynchronous), all registers cleared immediately:
  - `drive_state` = 00, `power_off` = 0, `kill` = 0, `reverse_q` = 0.
  - `phase` = 1, counters = 0, `mileage` = 0.
  - The LED and `reversing` outputs evaluate to 0 because `mode` is ignored.
- Reset deassertion takes effect at the next `clk` edge. Reset mid-operation discards state and mileage.
- `drive_state` changes on the edge that samples the causing inputs, giving 1-cycle latency.
- `power_off` timing:
  - It is high exactly one cycle, starting on the edge that samples the illegal condition.
  - The power block registers `break` on the following edge, so `mode` reads 00 one cycle after the pulse.
  - `kill` blocks repeat pulses if `mode` stays 01.
- Output timing:
  - `reversing` and the LEDs are combinational from registers and inputs.
  - `mileage` updates on the edge ending the `MILE_DIV`-th consecutive MOVING cycle.
- Simultaneous events: priority order as listed above. `brake` beats a throttle-to-MOVING request in STARTING. An illegal reverse change in MOVING beats `brake`.
- Mode change mid-drive (01 → 11 or 00): NOT_STARTING on the next edge. No `power_off` is issued.

## Test plan
- **Start sequence.** Reset, then `mode`=01, `clutch`=1, `throttle`=1 for 1 cycle → `drive_state`=01. Then `clutch`=0, `throttle`=1 → `drive_state`=10 one cycle later.
- **Stall kill.** In NOT_STARTING, `throttle`=1, `clutch`=0, with `mode` held at 01 for 10 cycles → exactly one `power_off` pulse, `drive_state` stays 00. Set `mode`=00 then 01 → a second identical stimulus yields one new pulse.
- **Reverse kill.** In MOVING, toggle `reverse` with `clutch`=0 → `power_off` pulse and `drive_state`=00. Repeat with `clutch`=1 → no pulse, `drive_state`=01, `reversing` follows `reverse`.
- **Mileage.** Hold MOVING for 500 cycles → `mileage` = 10. Hold 49 cycles, drop to STARTING, return for 49 → no increment. Preload near saturation (`MILE_W`=4) → `mileage` sticks at 15.
- **Blink.** `turn_left`=1 → `left_led`=1 for 250 cycles, 0 for 250, repeating. `right_led`=0 throughout. Both switches on → both LEDs in phase. `mode`=10 → both LEDs 0.
- **Async reset mid-drive.** In MOVING with `mileage`=7, pulse `rst_n` low between edges → all outputs 0 immediately, `drive_state`=00, `mileage`=0.
